pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_sat_counter.sv | 24 ++
 rtl/pipe_stage_reg.sv | 115 +++++++++++
 tb/tb_pipe_stage_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and state encoding for pipeline stage registers
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter
// Counts cycles where inc is high and sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and perf counters
// Holds up to two beats (SKID=1) or one beat (SKID=0) between pipeline stages.
module pipe_stage_reg #(
  parameter int          WIDTH     = 96,
  parameter int          SKID      = 1,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  import pipe_pkg::*;

  stage_state_e     r_state;
  logic [WIDTH-1:0] r_out_data;
  logic [31:0]      r_out_instr;
  logic [WIDTH-1:0] r_skid_data;
  logic [31:0]      r_skid_instr;

  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid & in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  // With the skid entry, in_ready is a pure state decode so out_ready never reaches it.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (r_state != ST_TWO);
    end else begin : g_noskid
      assign in_ready = ~w_out_valid | out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_out_data   <= '0;
      r_out_instr  <= NOP_INSTR;
      r_skid_data  <= '0;
      r_skid_instr <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= ST_ONE;
            r_out_data  <= in_data;
            r_out_instr <= in_instr;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_out_data  <= in_data;
            r_out_instr <= in_instr;
          end else if (w_in_fire) begin
            r_state      <= ST_TWO;
            r_skid_data  <= in_data;
            r_skid_instr <= in_instr;
          end else if (w_out_fire) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            r_state     <= ST_ONE;
            r_out_data  <= r_skid_data;
            r_out_instr <= r_skid_instr;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid = w_out_valid;
  assign out_data  = r_out_data;
  assign out_instr = w_out_valid ? r_out_instr : NOP_INSTR;

  logic w_stall_inc;
  logic w_bubble_inc;

  assign w_stall_inc  = w_out_valid & ~out_ready;
  assign w_bubble_inc = ~w_out_valid;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_bubble_inc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int          W    = 96;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h00A0_0093;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, flush, out_ready;
  logic [W-1:0]  in_data;
  logic [31:0]   in_instr;

  logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [W-1:0]  a_out_data, b_out_data, c_out_data;
  logic [31:0]   a_out_instr, b_out_instr, c_out_instr;
  logic [15:0]   a_stall, a_bub, b_stall, b_bub;
  logic [3:0]    c_stall, c_bub;

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_instr(in_instr), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_instr(a_out_instr), .stall_cnt(a_stall), .bubble_cnt(a_bub));

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_instr(in_instr), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_instr(b_out_instr), .stall_cnt(b_stall), .bubble_cnt(b_bub));

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .in_instr(in_instr), .flush(flush), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_instr(c_out_instr), .stall_cnt(c_stall), .bubble_cnt(c_bub));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a FIFO of held beats with capacity 2 (skid) or 1, plus raw event counts.
  typedef struct packed {
    logic [W-1:0] d;
    logic [31:0]  i;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int sa = 0, ba = 0, sb = 0, bb = 0;
  beat_t fa, fb;

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  always @(posedge clk) begin
    bit va, vb, ra, rb;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      sa = 0; ba = 0; sb = 0; bb = 0;
    end else begin
      va = (qa.size() != 0);
      vb = (qb.size() != 0);
      ra = (qa.size() < 2);
      rb = (qb.size() == 0) || out_ready;
      if (va && !out_ready) sa++;
      if (!va) ba++;
      if (vb && !out_ready) sb++;
      if (!vb) bb++;
      if (va && out_ready) void'(qa.pop_front());
      if (vb && out_ready) void'(qb.pop_front());
      if (in_valid && ra) qa.push_back('{in_data, in_instr});
      if (in_valid && rb) qb.push_back('{in_data, in_instr});
      if (flush) begin
        qa.delete();
        qb.delete();
      end
    end
  end

  task automatic cmp_stage(input string nm, input logic ov, input logic [W-1:0] od,
                           input logic [31:0] oi, input logic ir, input int st, input int bu,
                           input int n, input beat_t f, input logic er, input int est, input int ebu);
    check({nm, " out_valid"}, 128'(ov), 128'(n != 0));
    check({nm, " out_instr"}, 128'(oi), 128'((n != 0) ? f.i : NOP));
    if (n != 0) check({nm, " out_data"}, 128'(od), 128'(f.d));
    check({nm, " in_ready"}, 128'(ir), 128'(er));
    check({nm, " stall_cnt"}, 128'(st), 128'(est));
    check({nm, " bubble_cnt"}, 128'(bu), 128'(ebu));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      fa = (qa.size() != 0) ? qa[0] : beat_t'(0);
      fb = (qb.size() != 0) ? qb[0] : beat_t'(0);
      cmp_stage("model A", a_out_valid, a_out_data, a_out_instr, a_in_ready, int'(a_stall), int'(a_bub),
                qa.size(), fa, qa.size() < 2, sat(sa, 16), sat(ba, 16));
      cmp_stage("model B", b_out_valid, b_out_data, b_out_instr, b_in_ready, int'(b_stall), int'(b_bub),
                qb.size(), fb, (qb.size() == 0) || out_ready, sat(sb, 16), sat(bb, 16));
      cmp_stage("model C", c_out_valid, c_out_data, c_out_instr, c_in_ready, int'(c_stall), int'(c_bub),
                qa.size(), fa, qa.size() < 2, sat(sa, 4), sat(ba, 4));
    end
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       fl;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       erdy;
    int         est;
  } vec_t;

  vec_t tbl [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_data = '0; in_instr = ADDI;
  endtask

  initial begin
    //            v     d    fl    ordy  ev    ed    erdy  stall
    tbl[0]  = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 0};
    tbl[1]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 0};
    tbl[2]  = '{1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 0};
    tbl[3]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 0};
    tbl[4]  = '{1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 0};
    tbl[5]  = '{1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1};
    tbl[6]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 2};
    tbl[7]  = '{1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 2};
    tbl[8]  = '{1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 2};
    tbl[9]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 2};
    tbl[10] = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 2};
    tbl[11] = '{1'b1, 8'd6, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 3};
    tbl[12] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4};
    tbl[13] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4};
    tbl[14] = '{1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 4};
    tbl[15] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4};

    idle();
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    rst_n = 1'b1;
    repeat (5) tick();
    check("reset out_valid", 128'(a_out_valid), 128'(0));
    check("reset out_instr", 128'(a_out_instr), 128'(NOP));
    check("reset out_data", 128'(a_out_data), 128'(0));
    check("reset in_ready", 128'(a_in_ready), 128'(1));
    check("idle bubble_cnt", 128'(a_bub), 128'(5));
    check("idle stall_cnt", 128'(a_stall), 128'(0));

    for (int k = 0; k < 16; k++) begin
      in_valid  = tbl[k].v;
      in_data   = W'(tbl[k].d);
      in_instr  = ADDI;
      flush     = tbl[k].fl;
      out_ready = tbl[k].ordy;
      tick();
      check($sformatf("row%0d out_valid", k), 128'(a_out_valid), 128'(tbl[k].ev));
      check($sformatf("row%0d in_ready", k), 128'(a_in_ready), 128'(tbl[k].erdy));
      check($sformatf("row%0d out_instr", k), 128'(a_out_instr), 128'(tbl[k].ev ? ADDI : NOP));
      if (tbl[k].ev) check($sformatf("row%0d out_data", k), 128'(a_out_data), 128'(tbl[k].ed));
      check($sformatf("row%0d stall_cnt", k), 128'(a_stall), 128'(tbl[k].est));
    end

    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("sat bubble_cnt w4", 128'(c_bub), 128'(15));
    check("sat bubble_cnt w16", 128'(a_bub), 128'(20));
    repeat (5) tick();
    check("sat bubble_cnt held", 128'(c_bub), 128'(15));
    check("sat bubble_cnt w16 later", 128'(a_bub), 128'(25));

    in_valid = 1'b1; out_ready = 1'b0; in_data = W'(8);
    tick();
    in_data = W'(9);
    tick();
    check("mid-stall in_ready", 128'(a_in_ready), 128'(0));
    check("mid-stall out_data", 128'(a_out_data), 128'(8));
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    check("rst mid out_valid", 128'(a_out_valid), 128'(0));
    check("rst mid in_ready", 128'(a_in_ready), 128'(1));
    check("rst mid stall_cnt", 128'(a_stall), 128'(0));
    check("rst mid bubble_cnt", 128'(a_bub), 128'(0));
    check("rst mid out_instr", 128'(a_out_instr), 128'(NOP));
    check("rst mid out_data", 128'(a_out_data), 128'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post-rst out_valid %0d", k), 128'(a_out_valid), 128'(0));
    end

    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(199) != 0);
      in_valid  = ($urandom_range(99) < 70);
      in_data   = {$urandom, $urandom, $urandom};
      in_instr  = $urandom;
      flush     = ($urandom_range(99) < 4);
      out_ready = ($urandom_range(99) < 60);
      tick();
    end

    idle();
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
